// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequences PLL divider reconfiguration and lock qualification.
// Runs entirely on the free-running reference clock. It holds the PLL in reset,
// waits for a run of consecutive synchronized lock cycles, and retries on timeout.
// While idle and locked, it automatically relocks if lock is lost.
//
// Ports:
//   clk, rst                      reference clock, synchronous active-high reset
//   req_valid / req_ready         request handshake
//   req_idsel/fbdsel/odsel        requested raw divider codes
//   pll_lock                      PLL LOCK (asynchronous, synchronized here)
//   pll_reset, pll_*sel           PLL control outputs (registered)
//   locked                        qualified lock status
//   done / error / lock_lost      single-cycle event pulses
module pll_reconfig_ctrl #(
    parameter logic [5:0]  DEF_IDSEL     = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL    = 6'd0,
    parameter logic [5:0]  DEF_ODSEL     = 6'd0,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 1000000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_idsel,
    input  logic [5:0] req_fbdsel,
    input  logic [5:0] req_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       done,
    output logic       error,
    output logic       lock_lost
);

    localparam int unsigned HoldW  = $clog2(RESET_CYCLES) + 1;
    localparam int unsigned StabW  = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned TmoW   = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRIES) + 1;

    // Terminal compares are made on the current count so the transition lands
    // on the cycle the count would reach its parameter value.
    localparam logic [HoldW-1:0]  HoldLast = HoldW'(RESET_CYCLES - 1);
    localparam logic [StabW-1:0]  StabLast = StabW'(STABLE_CYCLES - 1);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(LOCK_TIMEOUT - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

    typedef enum logic [1:0] {
        StIdle,
        StResetHold,
        StWaitLock
    } state_e;

    state_e            state_q, state_d;
    logic              lock_meta_q, lock_s_q;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [StabW-1:0]  stab_q, stab_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [5:0]        idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
    logic              pll_reset_q, pll_reset_d;
    logic              locked_q, locked_d;
    logic              done_q, done_d, error_q, error_d, lost_q, lost_d;
    logic              lock_drop;

    // Two-flop synchronizer; lock_s_q is the only lock view used by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StResetHold;
            hold_q      <= '0;
            stab_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            idsel_q     <= DEF_IDSEL;
            fbdsel_q    <= DEF_FBDSEL;
            odsel_q     <= DEF_ODSEL;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            pll_reset_q <= pll_reset_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            error_q     <= error_d;
            lost_q      <= lost_d;
        end
    end

    assign lock_drop = locked_q && !lock_s_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stab_d      = stab_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        idsel_d     = idsel_q;
        fbdsel_d    = fbdsel_q;
        odsel_d     = odsel_q;
        pll_reset_d = pll_reset_q;
        locked_d    = locked_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        lost_d      = 1'b0;

        case (state_q)
            StIdle: begin
                lost_d = lock_drop;
                // A new request takes priority over auto-relock with the old codes.
                if (req_valid || lock_drop) begin
                    if (req_valid) begin
                        idsel_d  = req_idsel;
                        fbdsel_d = req_fbdsel;
                        odsel_d  = req_odsel;
                    end
                    state_d     = StResetHold;
                    hold_d      = '0;
                    retry_d     = '0;
                    pll_reset_d = 1'b1;
                    locked_d    = 1'b0;
                end
            end
            StResetHold: begin
                if (hold_q == HoldLast) begin
                    state_d     = StWaitLock;
                    pll_reset_d = 1'b0;
                    stab_d      = '0;
                    tmo_d       = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StWaitLock: begin
                tmo_d  = tmo_q + 1'b1;
                stab_d = lock_s_q ? stab_q + 1'b1 : '0;
                // Success is checked first so it wins over a coincident timeout.
                if (lock_s_q && stab_q == StabLast) begin
                    state_d  = StIdle;
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                end else if (tmo_q == TmoLast) begin
                    if (retry_q < RetryMax) begin
                        retry_d     = retry_q + 1'b1;
                        state_d     = StResetHold;
                        hold_d      = '0;
                        pll_reset_d = 1'b1;
                    end else begin
                        state_d  = StIdle;
                        locked_d = 1'b0;
                        error_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = StResetHold;
                hold_d      = '0;
                pll_reset_d = 1'b1;
            end
        endcase
    end

    assign req_ready  = (state_q == StIdle) && !rst;
    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign locked     = locked_q;
    assign done       = done_q;
    assign error      = error_q;
    assign lock_lost  = lost_q;

endmodule
